aes_round_sequencer: RTL

//  Sequences one AES block through the iterative round datapath built around the
//  4-column MixColumns stage. Accepts a start/decrypt request and fetches round keys
//  via a key_req/key_valid handshake. Drives load/capture enables, the MixColumns

---
 rtl/aes_round_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps one block through load, NR rounds and the final round.
// Latency: done pulses 2*NR+1 cycles after accept (key_valid high, MIX_LAT=1), +NR-1 per extra MIX_LAT cycle.
// Backpressure: stalls in LOAD/RND/FINAL while key_valid is low; start accepted only while ready.
module aes_round_sequencer #(
  parameter int NR      = 10,
  parameter int MIX_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       decrypt,
  input  logic       abort,
  input  logic       key_valid,
  output logic       ready,
  output logic       busy,
  output logic       inverse,
  output logic       key_req,
  output logic [3:0] key_idx,
  output logic       load_state,
  output logic       round_en,
  output logic       mix_bypass,
  output logic [3:0] round,
  output logic       done
);

  localparam int CW = (MIX_LAT > 1) ? $clog2(MIX_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, RND, MIX, FINAL, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [3:0]     round_nxt;
  logic           inverse_nxt;

  // State, MixColumns wait counter, round number and direction registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      round   <= '0;
      inverse <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      round   <= round_nxt;
      inverse <= inverse_nxt;
    end
  end

  // Next-state and datapath control; abort overrides everything below reset
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    round_nxt   = round;
    inverse_nxt = inverse;
    key_req     = 1'b0;
    load_state  = 1'b0;
    round_en    = 1'b0;
    mix_bypass  = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = LOAD;
          inverse_nxt = decrypt;
          round_nxt   = 4'd0;
        end
      end
      LOAD: begin
        key_req = 1'b1;
        if (key_valid) begin
          load_state = 1'b1;
          round_nxt  = 4'd1;
          state_nxt  = (NR > 1) ? RND : FINAL;
        end
      end
      RND: begin
        key_req = 1'b1;
        if (key_valid) begin
          state_nxt = MIX;
          cnt_nxt   = CW'(MIX_LAT - 1);
        end
      end
      MIX: begin
        if (cnt == '0) begin
          round_en  = 1'b1;
          round_nxt = round + 4'd1;
          state_nxt = ((round + 4'd1) == 4'(NR)) ? FINAL : RND;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      FINAL: begin
        key_req    = 1'b1;
        mix_bypass = 1'b1;
        if (key_valid) begin
          round_en  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
        round_nxt = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        round_nxt = 4'd0;
      end
    endcase
    // A cancelled block must not touch the datapath or report completion
    if (abort) begin
      state_nxt  = IDLE;
      round_nxt  = 4'd0;
      load_state = 1'b0;
      round_en   = 1'b0;
      done       = 1'b0;
    end
  end

  // Status and key index decode; decrypt walks the key schedule backwards
  always_comb begin
    ready   = (state == IDLE) && !abort;
    busy    = (state != IDLE);
    key_idx = 4'd0;
    if (state != IDLE)
      key_idx = inverse ? (4'(NR) - round) : round;
  end

endmodule
